// File: rtl/fwd_hazard_unit_if.sv
// ID-to-hazard-unit bundle: decoded ID fields in, operand-mux selects and stall out.
// FWD_STALL_CNT_EN adds the stall_cnt_o counter signal.
interface fwd_hazard_unit_if #(
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  id_valid_i;
  logic [REG_ADDR_W-1:0] id_rs_i;
  logic [REG_ADDR_W-1:0] id_rt_i;
  logic [REG_ADDR_W-1:0] id_rd_i;
  logic                  id_regwrite_i;
  logic                  id_memread_i;
  logic                  flush_i;
  logic [1:0]            fwd_a_o;
  logic [1:0]            fwd_b_o;
  logic                  stall_o;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]           stall_cnt_o;
`endif

  // The ID stage side.
  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
`ifdef FWD_STALL_CNT_EN
    input  stall_cnt_o,
`endif
    input  fwd_a_o, fwd_b_o, stall_o
  );

  // The hazard unit side.
  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
`ifdef FWD_STALL_CNT_EN
    output stall_cnt_o,
`endif
    output fwd_a_o, fwd_b_o, stall_o
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding / load-use hazard unit for the 5-stage pipeline: tracks EX/MEM/WB destinations and
// drives the ALU operand-mux selects and the stall. FWD_STALL_CNT_EN adds a saturating stall counter.
module fwd_hazard_unit #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic               clk_i,
  input logic               rst_i,
  fwd_hazard_unit_if.slave  bus
);
  typedef logic [REG_ADDR_W-1:0] addr_t;

  localparam logic [1:0] SelRegfile = 2'b00;
  localparam logic [1:0] SelExMem   = 2'b01;
  localparam logic [1:0] SelMemWb   = 2'b10;

  addr_t ex_rs_q, ex_rt_q, ex_rd_q, mem_rd_q, wb_rd_q;
  logic  ex_regwrite_q, ex_memread_q, mem_regwrite_q, wb_regwrite_q;
  logic  load_use, stall, ex_load;

  // The youngest producer (MEM) wins; r0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(input addr_t src, input addr_t m_rd, input logic m_rw,
                                         input addr_t w_rd, input logic w_rw);
    logic [1:0] sel;
    sel = SelRegfile;
    if (m_rw && (m_rd != '0) && (m_rd == src)) begin
      sel = SelExMem;
    end else if (w_rw && (w_rd != '0) && (w_rd == src)) begin
      sel = SelMemWb;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = bus.id_valid_i && ex_memread_q && (ex_rd_q != '0) &&
               ((ex_rd_q == bus.id_rs_i) || (ex_rd_q == bus.id_rt_i));
    stall    = load_use && !bus.flush_i;
    ex_load  = bus.id_valid_i && !bus.flush_i && !stall;
  end

  assign bus.stall_o = stall;
  assign bus.fwd_a_o = fwd_sel(ex_rs_q, mem_rd_q, mem_regwrite_q, wb_rd_q, wb_regwrite_q);
  assign bus.fwd_b_o = fwd_sel(ex_rt_q, mem_rd_q, mem_regwrite_q, wb_rd_q, wb_regwrite_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_rd_q        <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_regwrite_q  <= 1'b0;
    end else begin
      wb_rd_q        <= mem_rd_q;
      wb_regwrite_q  <= mem_regwrite_q;
      mem_rd_q       <= ex_rd_q;
      mem_regwrite_q <= ex_regwrite_q;
      if (ex_load) begin
        ex_rs_q       <= bus.id_rs_i;
        ex_rt_q       <= bus.id_rt_i;
        ex_rd_q       <= bus.id_rd_i;
        ex_regwrite_q <= bus.id_regwrite_i;
        ex_memread_q  <= bus.id_memread_i;
      end else begin
        // Bubble: clearing memread is what bounds a load-use stall to one cycle.
        ex_rs_q       <= '0;
        ex_rt_q       <= '0;
        ex_rd_q       <= '0;
        ex_regwrite_q <= 1'b0;
        ex_memread_q  <= 1'b0;
      end
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit: each vector drives ID on the falling edge and checks
// the selects/stall 1 ns later, before the next rising edge.
module tb_fwd_hazard_unit;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  fwd_hazard_unit_if #(.REG_ADDR_W(5)) hif ();

  fwd_hazard_unit #(.REG_ADDR_W(5)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (hif)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    hif.id_valid_i    = v;
    hif.id_rs_i       = rs;
    hif.id_rt_i       = rt;
    hif.id_rd_i       = rd;
    hif.id_regwrite_i = rw;
    hif.id_memread_i  = mr;
    hif.flush_i       = fl;
  endtask

  // Present one ID instruction for a cycle and settle before checking.
  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    @(negedge clk_i);
    set_id(v, rs, rt, rd, rw, mr, fl);
    #1;
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_fwd_a", {30'd0, hif.fwd_a_o}, 32'd0);
    check("rst_fwd_b", {30'd0, hif.fwd_b_o}, 32'd0);
    check("rst_stall", {31'd0, hif.stall_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // 1: reset mid-stream with a load in EX matching ID and an EX/MEM forward live.
    issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3
    issue(1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);   // lw r3,(r3)
    issue(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);   // add r4,r3,r3
    check("pre_rst_fwd_a", {30'd0, hif.fwd_a_o}, 32'd1);
    check("pre_rst_stall", {31'd0, hif.stall_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    check("mid_rst_fwd_a", {30'd0, hif.fwd_a_o}, 32'd0);
    check("mid_rst_fwd_b", {30'd0, hif.fwd_b_o}, 32'd0);
    check("mid_rst_stall", {31'd0, hif.stall_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    set_id(1'b1, 5'd3, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0);   // add r5,r3,r3
`ifdef FWD_STALL_CNT_EN
    #1;
    check("rst_cnt", hif.stall_cnt_o, 32'd0);
`endif
    nop();
    check("post_rst_fwd_a", {30'd0, hif.fwd_a_o}, 32'd0);
    check("post_rst_fwd_b", {30'd0, hif.fwd_b_o}, 32'd0);

    // 2: EX/MEM forward.
    issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3,r1,r2
    issue(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);   // sub r5,r3,r4
    nop();
    check("exmem_fwd_a", {30'd0, hif.fwd_a_o}, 32'd1);
    check("exmem_fwd_b", {30'd0, hif.fwd_b_o}, 32'd0);

    // 3a: MEM/WB forward across a nop.
    issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3
    nop();
    issue(1'b1, 5'd4, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0);   // and r6,r4,r3
    nop();
    check("memwb_fwd_a", {30'd0, hif.fwd_a_o}, 32'd0);
    check("memwb_fwd_b", {30'd0, hif.fwd_b_o}, 32'd2);

    // 3b: both stages match, MEM wins.
    issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3
    issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);   // add r3
    issue(1'b1, 5'd3, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);   // or r7,r3,r3
    nop();
    check("prio_fwd_a", {30'd0, hif.fwd_a_o}, 32'd1);
    check("prio_fwd_b", {30'd0, hif.fwd_b_o}, 32'd1);

    // 5: r0 never forwards nor stalls.
    issue(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);   // addi r0,r1
    issue(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);   // add r1,r0,r0
    nop();
    check("r0_fwd_a", {30'd0, hif.fwd_a_o}, 32'd0);
    check("r0_fwd_b", {30'd0, hif.fwd_b_o}, 32'd0);
    issue(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw r0,(r1)
    issue(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);   // add r2,r0,r0
    check("r0_stall", {31'd0, hif.stall_o}, 32'd0);
    nop();

    // 4: load-use stalls one cycle, bubble enters EX, then MEM/WB forward.
    issue(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0);   // lw r2,(r1)
    issue(1'b1, 5'd2, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0);   // add r4,r2,r1
    check("lu_stall", {31'd0, hif.stall_o}, 32'd1);
    issue(1'b1, 5'd2, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0);   // add held in IF/ID
    check("lu_stall_end", {31'd0, hif.stall_o}, 32'd0);
    check("lu_bubble_fwd_a", {30'd0, hif.fwd_a_o}, 32'd0);
`ifdef FWD_STALL_CNT_EN
    check("lu_cnt", hif.stall_cnt_o, 32'd1);
`endif
    nop();
    check("lu_fwd_a", {30'd0, hif.fwd_a_o}, 32'd2);
    check("lu_fwd_b", {30'd0, hif.fwd_b_o}, 32'd0);

    // 6: flush beats load-use; the squashed add must not forward.
    issue(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0);   // lw r2,(r1)
    issue(1'b1, 5'd2, 5'd1, 5'd4, 1'b1, 1'b0, 1'b1);   // add r4,r2,r1 squashed
    check("flush_stall", {31'd0, hif.stall_o}, 32'd0);
    issue(1'b1, 5'd4, 5'd4, 5'd8, 1'b1, 1'b0, 1'b0);   // and r8,r4,r4
    check("flush_next_stall", {31'd0, hif.stall_o}, 32'd0);
    nop();
    check("flush_fwd_a", {30'd0, hif.fwd_a_o}, 32'd0);
    check("flush_fwd_b", {30'd0, hif.fwd_b_o}, 32'd0);
`ifdef FWD_STALL_CNT_EN
    check("final_cnt", hif.stall_cnt_o, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
